// File: rtl/cache_pkg.sv
// Shared types for the cache miss-handling blocks.
//   state_t    : eviction/allocation controller FSM states
//   line_bits(): bits in a cache line for a given line size in bytes
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WB_REQ,
    FETCH_REQ,
    FETCH_WAIT,
    ALLOCATE
  } state_t;

  function automatic int line_bits(input int block_size);
    return block_size * 8;
  endfunction

endpackage

// File: rtl/evict_alloc_controller_if.sv
// Bus bundle between the eviction/allocation controller and its environment.
//   miss_*        : miss request handshake (valid/ready) and address
//   way_*         : tag/state/data view of the indexed set
//   mem_req_*     : line writeback / fetch request to memory (valid/ready)
//   mem_resp_*    : fetch response pulse and data
//   evict_target, alloc_en, alloc_data, done : allocation into the set
// master = controller side, slave = cache/memory side.
interface evict_alloc_controller_if #(
  parameter int NUM_WAYS      = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_BITS     = 256
);
  logic                              miss_valid;
  logic                              miss_ready;
  logic [ADDRESS_WIDTH-1:0]          miss_addr;
  logic [NUM_WAYS-1:0]               way_valid;
  logic [NUM_WAYS-1:0]               way_dirty;
  logic [NUM_WAYS*ADDRESS_WIDTH-1:0] way_line_addr;
  logic [NUM_WAYS*LINE_BITS-1:0]     way_rdata;
  logic                              mem_req_valid;
  logic                              mem_req_ready;
  logic                              mem_req_write;
  logic [ADDRESS_WIDTH-1:0]          mem_req_addr;
  logic [LINE_BITS-1:0]              mem_wdata;
  logic                              mem_resp_valid;
  logic [LINE_BITS-1:0]              mem_rdata;
  logic [NUM_WAYS-1:0]               evict_target;
  logic                              alloc_en;
  logic [LINE_BITS-1:0]              alloc_data;
  logic                              done;

  modport master (
    input  miss_valid, miss_addr, way_valid, way_dirty, way_line_addr, way_rdata,
           mem_req_ready, mem_resp_valid, mem_rdata,
    output miss_ready, mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
           evict_target, alloc_en, alloc_data, done
  );

  modport slave (
    output miss_valid, miss_addr, way_valid, way_dirty, way_line_addr, way_rdata,
           mem_req_ready, mem_resp_valid, mem_rdata,
    input  miss_ready, mem_req_valid, mem_req_write, mem_req_addr, mem_wdata,
           evict_target, alloc_en, alloc_data, done
  );
endinterface

// File: rtl/victim_select.sv
// Victim way picker.
//   way_valid    : per-way valid bits
//   pointer      : round-robin pointer, used only when every way is valid
//   victim       : one-hot victim way
//   from_pointer : victim came from the pointer (caller advances it)
module victim_select
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int PTR_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic [PTR_W-1:0]    pointer,
  output logic [NUM_WAYS-1:0] victim,
  output logic                from_pointer
);
  logic [NUM_WAYS-1:0] free_lsb;

  always_comb begin
    // ~v & (v+1) isolates the lowest clear bit; it is zero when all are set.
    free_lsb     = ~way_valid & (way_valid + NUM_WAYS'(1));
    from_pointer = &way_valid;
    victim       = from_pointer ? (NUM_WAYS'(1) << pointer) : free_lsb;
  end
endmodule

// File: rtl/evict_alloc_controller.sv
// Miss handler: picks a victim way, writes it back if dirty, fetches the
// missing line and allocates it into the victim way.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : evict_alloc_controller_if master (miss, set view, memory,
//                  allocation signals)
// All outputs are registered and change on state transitions.
module evict_alloc_controller
  import cache_pkg::*;
#(
  parameter int NUM_WAYS      = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  evict_alloc_controller_if.master  bus
);
  localparam int LINE_BITS = line_bits(BLOCK_SIZE);
  localparam int PTR_W     = $clog2(NUM_WAYS);
  localparam int AW        = ADDRESS_WIDTH;
  localparam logic [AW-1:0] LINE_MASK = ~AW'(BLOCK_SIZE - 1);

  state_t                state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [AW-1:0]         miss_line;
  logic [NUM_WAYS-1:0]   victim;
  logic                  from_ptr;
  logic [AW-1:0]         victim_addr;
  logic [LINE_BITS-1:0]  victim_data;
  logic                  victim_dirty;

  victim_select #(.NUM_WAYS(NUM_WAYS), .PTR_W(PTR_W)) u_vsel (
    .way_valid    (bus.way_valid),
    .pointer      (rr_ptr),
    .victim       (victim),
    .from_pointer (from_ptr)
  );

  // One-hot mux of the victim's address and data.
  always_comb begin
    victim_addr = '0;
    victim_data = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (victim[i]) begin
        victim_addr = victim_addr | bus.way_line_addr[i*AW +: AW];
        victim_data = victim_data | bus.way_rdata[i*LINE_BITS +: LINE_BITS];
      end
    end
    // An invalid way carries no data worth writing back, dirty bit or not.
    victim_dirty = |(victim & bus.way_valid & bus.way_dirty);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      miss_line         <= '0;
      bus.miss_ready    <= 1'b1;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_write <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.mem_wdata     <= '0;
      bus.evict_target  <= '0;
      bus.alloc_en      <= 1'b0;
      bus.alloc_data    <= '0;
      bus.done          <= 1'b0;
    end else begin
      // Allocation strobes last exactly the ALLOCATE cycle.
      bus.alloc_en   <= 1'b0;
      bus.alloc_data <= '0;
      bus.done       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.miss_valid) begin
            miss_line      <= bus.miss_addr & LINE_MASK;
            bus.miss_ready <= 1'b0;
            state          <= SELECT;
          end
        end
        SELECT: begin
          bus.evict_target  <= victim;
          bus.mem_req_valid <= 1'b1;
          if (from_ptr) rr_ptr <= rr_ptr + PTR_W'(1);
          if (victim_dirty) begin
            bus.mem_req_write <= 1'b1;
            bus.mem_req_addr  <= victim_addr & LINE_MASK;
            bus.mem_wdata     <= victim_data;
            state             <= WB_REQ;
          end else begin
            bus.mem_req_write <= 1'b0;
            bus.mem_req_addr  <= miss_line;
            state             <= FETCH_REQ;
          end
        end
        WB_REQ: begin
          // valid stays high straight into the fetch request
          if (bus.mem_req_ready) begin
            bus.mem_req_write <= 1'b0;
            bus.mem_req_addr  <= miss_line;
            bus.mem_wdata     <= '0;
            state             <= FETCH_REQ;
          end
        end
        FETCH_REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
            state             <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (bus.mem_resp_valid) begin
            bus.alloc_en   <= 1'b1;
            bus.alloc_data <= bus.mem_rdata;
            bus.done       <= 1'b1;
            state          <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          bus.evict_target <= '0;
          bus.miss_ready   <= 1'b1;
          state            <= IDLE;
        end
        default: begin
          state          <= IDLE;
          bus.miss_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_evict_alloc_controller.sv
module tb_evict_alloc_controller;
  localparam int NW = 4, AW = 32, BS = 32, LB = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  evict_alloc_controller_if #(.NUM_WAYS(NW), .ADDRESS_WIDTH(AW), .LINE_BITS(LB)) bus ();

  evict_alloc_controller #(.NUM_WAYS(NW), .ADDRESS_WIDTH(AW), .BLOCK_SIZE(BS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int                m_ptr = 0;
  logic [NW-1:0]     e_target;
  logic              e_wb;
  logic [AW-1:0]     e_wb_addr, e_fetch_addr;
  logic [LB-1:0]     e_wb_data, e_line;

  function automatic logic [AW-1:0] way_addr(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100 + 32'h40;
  endfunction

  function automatic logic [LB-1:0] way_data(input int i);
    logic [31:0] w;
    w = 32'hD000_0000 | 32'(i);
    return {8{w}};
  endfunction

  // First empty way wins; a full set falls back to the rotating pointer.
  function automatic logic [NW-1:0] model_victim(input logic [NW-1:0] v, input int ptr,
                                                 output bit from_ptr);
    logic [NW-1:0] oh;
    from_ptr = 1'b1;
    oh = '0;
    oh[ptr] = 1'b1;
    for (int i = NW - 1; i >= 0; i--)
      if (!v[i]) begin oh = '0; oh[i] = 1'b1; from_ptr = 1'b0; end
    return oh;
  endfunction

  task automatic setup_ways(input logic [NW-1:0] v, input logic [NW-1:0] d);
    bus.way_valid = v;
    bus.way_dirty = d;
    for (int i = 0; i < NW; i++) begin
      bus.way_line_addr[i*AW +: AW] = way_addr(i);
      bus.way_rdata[i*LB +: LB]     = way_data(i);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  bit             busy = 0;
  int             alloc_cnt = 0;
  logic           pv = 0, pr = 0, pw = 0;
  logic [AW-1:0]  pa = '0;
  logic [LB-1:0]  pd = '0;
  logic [NW-1:0]  seen_target = '0;
  logic [AW-1:0]  seen_fetch = '0, seen_wb_addr = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      busy = 0;
      pv = 0;
      chk("rst_miss_ready", bus.miss_ready, 1);
      chk("rst_req_valid", bus.mem_req_valid, 0);
      chk("rst_target", bus.evict_target, 0);
      chk("rst_alloc_en", bus.alloc_en, 0);
      chk("rst_done", bus.done, 0);
    end else begin
      chk("miss_ready", bus.miss_ready, !busy);
      chk("done_eq_alloc", bus.done, bus.alloc_en);
      if (!busy) begin
        chk("idle_target", bus.evict_target, 0);
        chk("idle_req_valid", bus.mem_req_valid, 0);
        chk("idle_alloc_en", bus.alloc_en, 0);
      end
      if (!bus.alloc_en) chk("alloc_data_zero", bus.alloc_data, 0);
      else begin
        alloc_cnt++;
        chk("alloc_data", bus.alloc_data, e_line);
        chk("alloc_target", bus.evict_target, e_target);
        seen_target = bus.evict_target;
      end
      if (!(bus.mem_req_valid && bus.mem_req_write)) chk("wdata_zero", bus.mem_wdata, 0);
      if (bus.mem_req_valid) begin
        chk("req_target", bus.evict_target, e_target);
        if (bus.mem_req_write) begin
          chk("wb_addr", bus.mem_req_addr, e_wb_addr);
          chk("wb_data", bus.mem_wdata, e_wb_data);
          seen_wb_addr = bus.mem_req_addr;
        end else begin
          chk("fetch_addr", bus.mem_req_addr, e_fetch_addr);
          seen_fetch = bus.mem_req_addr;
        end
      end
      if (pv && !pr) begin
        chk("hold_valid", bus.mem_req_valid, 1);
        chk("hold_write", bus.mem_req_write, pw);
        chk("hold_addr", bus.mem_req_addr, pa);
        chk("hold_wdata", bus.mem_wdata, pd);
      end
      pv = bus.mem_req_valid; pr = bus.mem_req_ready; pw = bus.mem_req_write;
      pa = bus.mem_req_addr;  pd = bus.mem_wdata;
      if (bus.miss_valid && bus.miss_ready) busy = 1;
      if (bus.done) busy = 0;
    end
  end

  // ---------------- stimulus ----------------
  // Drives one miss to completion; memory answers immediately except for
  // 'stall' cycles of ready low on a writeback. abort stops in FETCH_WAIT.
  task automatic run_miss(input logic [AW-1:0] addr, input logic [NW-1:0] v,
                          input logic [NW-1:0] d, input int stall, input logic [LB-1:0] line,
                          input bit abort, output int lat, output int wbcyc);
    int idx, edges;
    bit fp, fw;
    setup_ways(v, d);
    e_target = model_victim(v, m_ptr, fp);
    idx = 0;
    for (int i = 0; i < NW; i++) if (e_target[i]) idx = i;
    e_wb         = v[idx] & d[idx];
    e_wb_addr    = way_addr(idx);
    e_wb_data    = way_data(idx);
    e_fetch_addr = addr & ~32'(BS - 1);
    e_line       = line;
    if (fp) m_ptr = (m_ptr + 1) % NW;
    lat = 0; wbcyc = 0; fw = 0;
    bus.miss_addr = addr;
    bus.mem_rdata = line;
    bus.mem_req_ready = 1'b1;
    bus.miss_valid = 1'b1;
    @(posedge clk); #1;
    bus.miss_valid = 1'b0;
    edges = 1;
    while (1) begin
      if (bus.done) begin lat = edges; break; end
      if (edges >= 60) begin
        checks++; failures++;
        $display("FAIL timeout waiting for done addr=%0h", addr);
        break;
      end
      bus.mem_resp_valid = 1'b0;
      if (fw) begin
        fw = 0;
        if (abort) return;
        bus.mem_resp_valid = 1'b1;
      end
      if (bus.mem_req_valid && bus.mem_req_write) begin
        wbcyc++;
        if (wbcyc == 2 && stall > 0) begin
          bus.way_rdata = '1;
          bus.way_line_addr = '1;
        end
        bus.mem_req_ready = (wbcyc > stall);
      end else bus.mem_req_ready = 1'b1;
      if (bus.mem_req_valid && !bus.mem_req_write && bus.mem_req_ready) fw = 1;
      @(posedge clk); #1;
      edges++;
    end
    bus.mem_resp_valid = 1'b0;
    chk("wb_issued", wbcyc != 0, e_wb);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, wbc, a0;
    logic [NW-1:0] tl [5];
    tl = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    bus.miss_valid = 0; bus.miss_addr = '0; bus.way_valid = '0; bus.way_dirty = '0;
    bus.way_line_addr = '0; bus.way_rdata = '0; bus.mem_req_ready = 0;
    bus.mem_resp_valid = 0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_miss_ready", bus.miss_ready, 1);
    chk("reset_req_valid", bus.mem_req_valid, 0);
    chk("reset_target", bus.evict_target, 0);
    chk("reset_done", bus.done, 0);

    // empty way 2 chosen, clean, minimum latency
    run_miss(32'h0000_1234, 4'b1011, 4'b0000, 0, {8{32'hCAFE_0001}}, 0, lat, wbc);
    chk("r37_model_target", e_target, 4'b0100);
    chk("r37_target", seen_target, 4'b0100);
    chk("r37_fetch_addr", seen_fetch, 32'h0000_1220);
    chk("r37_latency", lat, 4);

    // full set, way0 dirty, pointer 0 -> writeback then fetch
    run_miss(32'h0000_5678, 4'b1111, 4'b0001, 0, {8{32'hCAFE_0002}}, 0, lat, wbc);
    chk("r38_wb_addr", seen_wb_addr, 32'h1000_0040);
    chk("r38_target", seen_target, 4'b0001);
    chk("r38_wb_cycles", wbc, 1);
    chk("r38_latency", lat, 5);
    chk("r38_model_ptr", m_ptr, 1);

    // pointer rotates through the remaining ways and wraps
    for (int k = 0; k < 5; k++) begin
      run_miss(32'h2000_0000 + 32'(k) * 32'h40 + 32'h7, 4'b1111, 4'b0000, 0,
               {8{32'hBEEF_0000 | 32'(k)}}, 0, lat, wbc);
      chk("r39_target", seen_target, tl[k]);
      chk("r39_latency", lat, 4);
    end

    // writeback held off 5 cycles; set view scrambled meanwhile
    run_miss(32'h3000_0010, 4'b1111, 4'b1111, 5, {8{32'hCAFE_0003}}, 0, lat, wbc);
    chk("r40_target", seen_target, 4'b0100);
    chk("r40_wb_addr", seen_wb_addr, 32'h1000_0240);
    chk("r40_wb_cycles", wbc, 6);

    // reset while waiting for fetch data
    run_miss(32'h4000_0000, 4'b1011, 4'b0000, 0, {8{32'hDEAD_0004}}, 1, lat, wbc);
    a0 = alloc_cnt;
    #2 reset_n = 1'b0;
    #1;
    chk("r41_async_ready", bus.miss_ready, 1);
    chk("r41_async_target", bus.evict_target, 0);
    chk("r41_async_done", bus.done, 0);
    m_ptr = 0;
    @(posedge clk); @(posedge clk);
    #1 reset_n = 1'b1;
    bus.mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("r41_no_alloc", alloc_cnt, a0);
    chk("r41_ready", bus.miss_ready, 1);

    // invalid way with a stale dirty bit: no writeback
    run_miss(32'hABCD_EF5F, 4'b0111, 4'b1000, 0, {8{32'hCAFE_0005}}, 0, lat, wbc);
    chk("inv_dirty_target", seen_target, 4'b1000);
    chk("inv_dirty_fetch", seen_fetch, 32'hABCD_EF40);
    chk("inv_dirty_wb", wbc, 0);
    chk("inv_dirty_latency", lat, 4);

    // pointer restarted from 0 by reset
    run_miss(32'h5000_0000, 4'b1111, 4'b0000, 0, {8{32'hCAFE_0006}}, 0, lat, wbc);
    chk("ptr_after_reset", seen_target, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
